// File: rtl/calc2_pkg.sv
// Command/response encodings, scheduler and capture state types, and the queued request record.
// Operand fields are sized for the widest supported DATA_W; narrower instances zero-fill the upper bits.
package calc2_pkg;

    localparam int NPORT      = 4;
    localparam int DATA_W_MAX = 64;

    localparam logic [3:0] CMD_NONE = 4'd0;
    localparam logic [3:0] CMD_ADD  = 4'd1;
    localparam logic [3:0] CMD_SUB  = 4'd2;
    localparam logic [3:0] CMD_SHL  = 4'd5;
    localparam logic [3:0] CMD_SHR  = 4'd6;

    localparam logic [1:0] RESP_NONE    = 2'd0;
    localparam logic [1:0] RESP_OK      = 2'd1;
    localparam logic [1:0] RESP_RANGE   = 2'd2;
    localparam logic [1:0] RESP_BAD_CMD = 2'd3;

    typedef enum logic [1:0] {
        SCH_IDLE = 2'd0,
        SCH_EXEC = 2'd1,
        SCH_RESP = 2'd2
    } sched_state_t;

    typedef enum logic {
        CAP_CMD = 1'b0,
        CAP_OP2 = 1'b1
    } cap_state_t;

    typedef struct packed {
        logic [3:0]            cmd;
        logic [1:0]            tag;
        logic [DATA_W_MAX-1:0] op1;
        logic [DATA_W_MAX-1:0] op2;
    } req_t;

endpackage

// File: rtl/calc2_req_fifo.sv
// Synchronous FIFO (power-of-two DEPTH >= 2), head data read combinationally; one-cycle write latency.
// Push is accepted when not full, or when full but popped in the same cycle; otherwise it is ignored.
module calc2_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    import calc2_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/calc2_port_sched.sv
// Four-port two-operand calculator: per-port capture + queue, round-robin scheduler, one ALU; operand2 to response in 3 cycles minimum.
// No input backpressure: a request arriving at a full queue is dropped and flagged in the sticky port_ovf.
module calc2_port_sched
    import calc2_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int Q_DEPTH = 4
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req1_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [1:0]        req1_tag_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [1:0]        req2_tag_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [1:0]        req3_tag_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [DATA_W-1:0] req4_data_in,
    input  logic [1:0]        req4_tag_in,
    output logic [1:0]        out_resp1,
    output logic [DATA_W-1:0] out_data1,
    output logic [1:0]        out_tag1,
    output logic [1:0]        out_resp2,
    output logic [DATA_W-1:0] out_data2,
    output logic [1:0]        out_tag2,
    output logic [1:0]        out_resp3,
    output logic [DATA_W-1:0] out_data3,
    output logic [1:0]        out_tag3,
    output logic [1:0]        out_resp4,
    output logic [DATA_W-1:0] out_data4,
    output logic [1:0]        out_tag4,
    output logic [3:0]        port_ovf
);

    localparam int FW = 6 + 2 * DATA_W;

    logic [3:0]        port_cmd [NPORT];
    logic [DATA_W-1:0] port_dat [NPORT];
    logic [1:0]        port_tag [NPORT];

    logic [1:0]        rsp_code [NPORT];
    logic [DATA_W-1:0] rsp_dat  [NPORT];
    logic [1:0]        rsp_tag  [NPORT];

    logic [FW-1:0]     q_dat [NPORT];
    logic [NPORT-1:0]  q_full;
    logic [NPORT-1:0]  q_empty;
    logic [NPORT-1:0]  q_pop;
    logic [NPORT-1:0]  q_drop;

    sched_state_t      sched_state;
    sched_state_t      sched_next;
    logic [1:0]        rr;
    logic [1:0]        rr_idx;
    logic [1:0]        pick;
    logic              any_req;
    logic [1:0]        grant;
    logic [FW-1:0]     head;
    req_t              pick_req;
    req_t              cur_req;
    req_t              unused_req;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W:0]   sum;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_dat;
    logic [1:0]        res_resp;
    logic [DATA_W-1:0] res_dat;

    assign port_cmd[0] = req1_cmd_in;
    assign port_cmd[1] = req2_cmd_in;
    assign port_cmd[2] = req3_cmd_in;
    assign port_cmd[3] = req4_cmd_in;
    assign port_dat[0] = req1_data_in;
    assign port_dat[1] = req2_data_in;
    assign port_dat[2] = req3_data_in;
    assign port_dat[3] = req4_data_in;
    assign port_tag[0] = req1_tag_in;
    assign port_tag[1] = req2_tag_in;
    assign port_tag[2] = req3_tag_in;
    assign port_tag[3] = req4_tag_in;

    assign out_resp1 = rsp_code[0];
    assign out_data1 = rsp_dat[0];
    assign out_tag1  = rsp_tag[0];
    assign out_resp2 = rsp_code[1];
    assign out_data2 = rsp_dat[1];
    assign out_tag2  = rsp_tag[1];
    assign out_resp3 = rsp_code[2];
    assign out_data3 = rsp_dat[2];
    assign out_tag3  = rsp_tag[2];
    assign out_resp4 = rsp_code[3];
    assign out_data4 = rsp_dat[3];
    assign out_tag4  = rsp_tag[3];

    // Per-port capture: command cycle latches cmd/tag/op1, the following cycle supplies op2 and pushes.
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        cap_state_t        cap_state;
        cap_state_t        cap_next;
        logic              push;
        logic [3:0]        cap_cmd;
        logic [1:0]        cap_tag;
        logic [DATA_W-1:0] cap_op1;

        always_ff @(posedge c_clk) begin
            if (reset) begin
                cap_state <= CAP_CMD;
            end else begin
                cap_state <= cap_next;
            end
        end

        always_comb begin
            cap_next = cap_state;
            if (cap_state == CAP_OP2) begin
                cap_next = CAP_CMD;
            end else if (port_cmd[p] != CMD_NONE) begin
                cap_next = CAP_OP2;
            end
        end

        always_comb begin
            push = (cap_state == CAP_OP2);
        end

        always_ff @(posedge c_clk) begin
            if (reset) begin
                cap_cmd <= '0;
                cap_tag <= '0;
                cap_op1 <= '0;
            end else if (cap_state == CAP_CMD && port_cmd[p] != CMD_NONE) begin
                cap_cmd <= port_cmd[p];
                cap_tag <= port_tag[p];
                cap_op1 <= port_dat[p];
            end
        end

        calc2_req_fifo #(
            .W     (FW),
            .DEPTH (Q_DEPTH)
        ) u_fifo (
            .clk      (c_clk),
            .reset    (reset),
            .push     (push),
            .push_dat ({cap_cmd, cap_tag, cap_op1, port_dat[p]}),
            .pop      (q_pop[p]),
            .pop_dat  (q_dat[p]),
            .full     (q_full[p]),
            .empty    (q_empty[p])
        );

        assign q_drop[p] = push && q_full[p] && !q_pop[p];
    end

    // Round-robin search starting at rr; first non-empty queue wins.
    always_comb begin
        pick    = rr;
        any_req = 1'b0;
        rr_idx  = '0;
        for (int i = 0; i < NPORT; i++) begin
            rr_idx = rr + 2'(i);
            if (!any_req && !q_empty[rr_idx]) begin
                pick    = rr_idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        head         = q_dat[pick];
        pick_req     = '0;
        pick_req.cmd = head[FW-1 -: 4];
        pick_req.tag = head[FW-5 -: 2];
        pick_req.op1[DATA_W-1:0] = head[2*DATA_W-1 -: DATA_W];
        pick_req.op2[DATA_W-1:0] = head[DATA_W-1:0];
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            sched_state <= SCH_IDLE;
        end else begin
            sched_state <= sched_next;
        end
    end

    always_comb begin
        sched_next = sched_state;
        case (sched_state)
            SCH_IDLE: if (any_req) sched_next = SCH_EXEC;
            SCH_EXEC: sched_next = SCH_RESP;
            SCH_RESP: sched_next = SCH_IDLE;
            default:  sched_next = SCH_IDLE;
        endcase
    end

    always_comb begin
        q_pop = '0;
        for (int i = 0; i < NPORT; i++) begin
            rsp_code[i] = RESP_NONE;
            rsp_dat[i]  = '0;
            rsp_tag[i]  = '0;
        end
        if (sched_state == SCH_IDLE && any_req) begin
            q_pop[pick] = 1'b1;
        end
        if (sched_state == SCH_RESP) begin
            rsp_code[grant] = res_resp;
            rsp_dat[grant]  = res_dat;
            rsp_tag[grant]  = cur_req.tag;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            rr       <= '0;
            grant    <= '0;
            cur_req  <= '0;
            res_resp <= RESP_NONE;
            res_dat  <= '0;
        end else begin
            if (sched_state == SCH_IDLE && any_req) begin
                grant   <= pick;
                rr      <= pick + 2'd1;
                cur_req <= pick_req;
            end
            if (sched_state == SCH_EXEC) begin
                res_resp <= alu_resp;
                res_dat  <= alu_dat;
            end
        end
    end

    // Operand bits above DATA_W are always zero and intentionally left unread.
    assign unused_req = cur_req;
    assign op1 = cur_req.op1[DATA_W-1:0];
    assign op2 = cur_req.op2[DATA_W-1:0];
    assign sum = {1'b0, op1} + {1'b0, op2};

    always_comb begin
        alu_resp = RESP_OK;
        alu_dat  = '0;
        case (cur_req.cmd)
            CMD_ADD: begin
                if (sum[DATA_W]) alu_resp = RESP_RANGE;
                else             alu_dat  = sum[DATA_W-1:0];
            end
            CMD_SUB: begin
                if (op1 < op2) alu_resp = RESP_RANGE;
                else           alu_dat  = op1 - op2;
            end
            CMD_SHL: alu_dat = op1 << op2[4:0];
            CMD_SHR: alu_dat = op1 >> op2[4:0];
            default: alu_resp = RESP_BAD_CMD;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            port_ovf <= '0;
        end else begin
            port_ovf <= port_ovf | q_drop;
        end
    end

endmodule
